// File: rtl/map_probe_scheduler_pkg.sv
// map_pkg: definitions shared by the neighbour-tile probe scheduler.
//   MAP_ROWS      tiles per map column
//   TILE_*        tile codes with special meaning to the probe logic
//   state_e       probe sequencer states
//   is_solid()    membership test for the solid tile set
package map_pkg;

  localparam int unsigned MAP_ROWS    = 15;
  localparam int unsigned TILE_CODE_W = 5;

  localparam logic [TILE_CODE_W-1:0] TILE_SKY   = 5'd0;
  localparam logic [TILE_CODE_W-1:0] TILE_HCL   = 5'd1;
  localparam logic [TILE_CODE_W-1:0] TILE_COIN  = 5'd12;
  localparam logic [TILE_CODE_W-1:0] TILE_LIGHT = 5'd13;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SNAP  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  function automatic logic is_solid(input logic [TILE_CODE_W-1:0] tile);
    logic res;
    case (tile)
      5'd1, 5'd3, 5'd5, 5'd6, 5'd11, 5'd14, 5'd15, 5'd20,
      5'd21, 5'd22, 5'd23, 5'd26, 5'd27, 5'd28, 5'd29: res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/map_probe_scheduler_tile_classify.sv
// tile_classify: combinational tile code -> {solid, hazard}.
//   tile    tile code
//   solid   tile belongs to the solid set
//   hazard  tile is the hazard tile; with CHECK_LIGHT set the light tile
//           also counts (only meaningful for the tile below Mario)
module tile_classify
  import map_pkg::*;
#(
  parameter int unsigned TILE_W      = 5,
  parameter logic        CHECK_LIGHT = 1'b0
) (
  input  logic [TILE_W-1:0] tile,
  output logic              solid,
  output logic              hazard
);

  logic [TILE_CODE_W-1:0] code;

  always_comb begin
    code   = TILE_CODE_W'(tile);
    solid  = is_solid(code);
    hazard = (code == TILE_HCL) || (CHECK_LIGHT && (code == TILE_LIGHT));
  end

endmodule

// File: rtl/map_probe_scheduler.sv
// map_probe_scheduler: sequences the four neighbour-tile lookups (front,
// back, up, down) for Mario over one shared map ROM read port and commits
// the tile codes plus derived solid/hazard flags atomically.
//   clk, reset            clock, asynchronous active-high reset
//   start                 probe request (level or pulse)
//   shift_map/mario_x/y   scroll offset and 1-based Mario tile position
//   rom_en/rom_addr       map ROM read port (data returns one cycle later)
//   rom_data              map ROM read data
//   *_tile, *_solid       committed neighbour tiles and solid flags
//   hazard                committed hazard flag
//   busy/done/valid       in progress / commit pulse / ever committed
module map_probe_scheduler
  import map_pkg::*;
#(
  parameter int unsigned ADDR_W   = 11,
  parameter int unsigned TILE_W   = 5,
  parameter int unsigned MAP_ROWS = map_pkg::MAP_ROWS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        shift_map,
  input  logic [4:0]        mario_x,
  input  logic [4:0]        mario_y,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [TILE_W-1:0] rom_data,
  output logic [TILE_W-1:0] front_tile,
  output logic [TILE_W-1:0] back_tile,
  output logic [TILE_W-1:0] up_tile,
  output logic [TILE_W-1:0] down_tile,
  output logic              front_solid,
  output logic              back_solid,
  output logic              up_solid,
  output logic              down_solid,
  output logic              hazard,
  output logic              busy,
  output logic              done,
  output logic              valid
);

  localparam logic [ADDR_W-1:0] ROWS_A = ADDR_W'(MAP_ROWS);

  state_e            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic              pending_q, pending_d;
  logic [7:0]        snap_s_q, snap_s_d;
  logic [4:0]        snap_x_q, snap_x_d;
  logic [4:0]        snap_y_q, snap_y_d;
  logic [TILE_W-1:0] sh_front_q, sh_front_d;
  logic [TILE_W-1:0] sh_back_q, sh_back_d;
  logic [TILE_W-1:0] sh_up_q, sh_up_d;
  logic [TILE_W-1:0] front_tile_q, front_tile_d;
  logic [TILE_W-1:0] back_tile_q, back_tile_d;
  logic [TILE_W-1:0] up_tile_q, up_tile_d;
  logic [TILE_W-1:0] down_tile_q, down_tile_d;
  logic              front_solid_q, front_solid_d;
  logic              back_solid_q, back_solid_d;
  logic              up_solid_q, up_solid_d;
  logic              down_solid_q, down_solid_d;
  logic              hazard_q, hazard_d;
  logic              done_q, done_d;
  logic              valid_q, valid_d;

  logic              c_front_solid, c_back_solid, c_up_solid, c_down_solid;
  logic              c_front_hz, c_back_hz, c_up_hz, c_down_hz;

  logic [ADDR_W-1:0] s_a, x_a, y_a, col_a, row_a, addr_calc;

  // Classifiers sit on the commit path: three on the shadow registers and
  // one directly on the final ROM datum, so everything commits on one edge.
  tile_classify #(.TILE_W(TILE_W), .CHECK_LIGHT(1'b0)) u_cls_front (
    .tile(sh_front_q), .solid(c_front_solid), .hazard(c_front_hz)
  );
  tile_classify #(.TILE_W(TILE_W), .CHECK_LIGHT(1'b0)) u_cls_back (
    .tile(sh_back_q), .solid(c_back_solid), .hazard(c_back_hz)
  );
  tile_classify #(.TILE_W(TILE_W), .CHECK_LIGHT(1'b0)) u_cls_up (
    .tile(sh_up_q), .solid(c_up_solid), .hazard(c_up_hz)
  );
  tile_classify #(.TILE_W(TILE_W), .CHECK_LIGHT(1'b1)) u_cls_down (
    .tile(rom_data), .solid(c_down_solid), .hazard(c_down_hz)
  );

  // Address arithmetic is done entirely in ADDR_W bits so that negative
  // column/row offsets wrap modulo 2^ADDR_W.
  always_comb begin
    s_a = ADDR_W'(snap_s_q);
    x_a = ADDR_W'(snap_x_q);
    y_a = ADDR_W'(snap_y_q);
    case (idx_q)
      2'd0:    begin col_a = x_a;                 row_a = y_a - ADDR_W'(1); end
      2'd1:    begin col_a = x_a - ADDR_W'(2);    row_a = y_a - ADDR_W'(1); end
      2'd2:    begin col_a = x_a - ADDR_W'(1);    row_a = y_a - ADDR_W'(2); end
      default: begin col_a = x_a - ADDR_W'(1);    row_a = y_a;              end
    endcase
    addr_calc = s_a * ROWS_A + col_a * ROWS_A + row_a;
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    pending_d     = pending_q;
    snap_s_d      = snap_s_q;
    snap_x_d      = snap_x_q;
    snap_y_d      = snap_y_q;
    sh_front_d    = sh_front_q;
    sh_back_d     = sh_back_q;
    sh_up_d       = sh_up_q;
    front_tile_d  = front_tile_q;
    back_tile_d   = back_tile_q;
    up_tile_d     = up_tile_q;
    down_tile_d   = down_tile_q;
    front_solid_d = front_solid_q;
    back_solid_d  = back_solid_q;
    up_solid_d    = up_solid_q;
    down_solid_d  = down_solid_q;
    hazard_d      = hazard_q;
    done_d        = 1'b0;
    valid_d       = valid_q;

    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_SNAP;
      end
      ST_SNAP: begin
        snap_s_d = shift_map;
        snap_x_d = mario_x;
        snap_y_d = mario_y;
        idx_d    = 2'd0;
        if (start) pending_d = 1'b1;
        state_d  = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (start) pending_d = 1'b1;
        // Data arriving now belongs to the read issued one cycle earlier.
        case (idx_q)
          2'd1:    sh_front_d = rom_data;
          2'd2:    sh_back_d  = rom_data;
          2'd3:    sh_up_d    = rom_data;
          default: ;
        endcase
        if (idx_q == 2'd3) state_d = ST_DRAIN;
        else               idx_d   = idx_q + 2'd1;
      end
      ST_DRAIN: begin
        front_tile_d  = sh_front_q;
        back_tile_d   = sh_back_q;
        up_tile_d     = sh_up_q;
        down_tile_d   = rom_data;
        front_solid_d = c_front_solid;
        back_solid_d  = c_back_solid;
        up_solid_d    = c_up_solid;
        down_solid_d  = c_down_solid;
        hazard_d      = c_front_hz | c_back_hz | c_up_hz | c_down_hz;
        done_d        = 1'b1;
        valid_d       = 1'b1;
        pending_d     = 1'b0;
        state_d       = (pending_q || start) ? ST_SNAP : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      pending_q     <= 1'b0;
      snap_s_q      <= '0;
      snap_x_q      <= '0;
      snap_y_q      <= '0;
      sh_front_q    <= '0;
      sh_back_q     <= '0;
      sh_up_q       <= '0;
      front_tile_q  <= '0;
      back_tile_q   <= '0;
      up_tile_q     <= '0;
      down_tile_q   <= '0;
      front_solid_q <= 1'b0;
      back_solid_q  <= 1'b0;
      up_solid_q    <= 1'b0;
      down_solid_q  <= 1'b0;
      hazard_q      <= 1'b0;
      done_q        <= 1'b0;
      valid_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      pending_q     <= pending_d;
      snap_s_q      <= snap_s_d;
      snap_x_q      <= snap_x_d;
      snap_y_q      <= snap_y_d;
      sh_front_q    <= sh_front_d;
      sh_back_q     <= sh_back_d;
      sh_up_q       <= sh_up_d;
      front_tile_q  <= front_tile_d;
      back_tile_q   <= back_tile_d;
      up_tile_q     <= up_tile_d;
      down_tile_q   <= down_tile_d;
      front_solid_q <= front_solid_d;
      back_solid_q  <= back_solid_d;
      up_solid_q    <= up_solid_d;
      down_solid_q  <= down_solid_d;
      hazard_q      <= hazard_d;
      done_q        <= done_d;
      valid_q       <= valid_d;
    end
  end

  always_comb begin
    rom_en      = (state_q == ST_ISSUE);
    rom_addr    = (state_q == ST_ISSUE) ? addr_calc : '0;
    busy        = (state_q != ST_IDLE);
    done        = done_q;
    valid       = valid_q;
    hazard      = hazard_q;
    front_tile  = front_tile_q;
    back_tile   = back_tile_q;
    up_tile     = up_tile_q;
    down_tile   = down_tile_q;
    front_solid = front_solid_q;
    back_solid  = back_solid_q;
    up_solid    = up_solid_q;
    down_solid  = down_solid_q;
  end

endmodule

// File: tb/tb_map_probe_scheduler.sv
// Directed bench for map_probe_scheduler with a synchronous ROM model.
module tb_map_probe_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  shift_map = '0;
  logic [4:0]  mario_x = '0;
  logic [4:0]  mario_y = '0;
  logic        rom_en;
  logic [10:0] rom_addr;
  logic [4:0]  rom_data = '0;
  logic [4:0]  front_tile, back_tile, up_tile, down_tile;
  logic        front_solid, back_solid, up_solid, down_solid;
  logic        hazard, busy, done, valid;

  int n_checks = 0;
  int n_fail   = 0;

  map_probe_scheduler #(.ADDR_W(11), .TILE_W(5), .MAP_ROWS(15)) dut (
    .clk(clk), .reset(reset), .start(start), .shift_map(shift_map),
    .mario_x(mario_x), .mario_y(mario_y), .rom_en(rom_en), .rom_addr(rom_addr),
    .rom_data(rom_data), .front_tile(front_tile), .back_tile(back_tile),
    .up_tile(up_tile), .down_tile(down_tile), .front_solid(front_solid),
    .back_solid(back_solid), .up_solid(up_solid), .down_solid(down_solid),
    .hazard(hazard), .busy(busy), .done(done), .valid(valid)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] rom_fn(input logic [10:0] a);
    case (a)
      11'd49: return 5'd3;     11'd35: return 5'd13;
      11'd15: return 5'd14;    11'd2033: return 5'd1;
      11'd2047: return 5'd28;  11'd79: return 5'd26;
      11'd63: return 5'd13;    11'd65: return 5'd13;
      11'd1116: return 5'd11;  11'd1086: return 5'd6;
      11'd1100: return 5'd1;   11'd1102: return 5'd5;
      11'd92: return 5'd12;    11'd62: return 5'd2;
      11'd76: return 5'd13;    11'd78: return 5'd4;
      11'd64: return 5'd20;    11'd34: return 5'd2;
      11'd48: return 5'd7;     11'd50: return 5'd12;
      default: return 5'd0;
    endcase
  endfunction

  always @(posedge clk) if (rom_en) rom_data <= rom_fn(rom_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  s;
    logic [4:0]  x, y;
    logic [10:0] a0, a1, a2, a3;
    logic [4:0]  t0, t1, t2, t3;
    logic [3:0]  sol;   // {front, back, up, down}
    logic        hz;
  } vec_t;

  vec_t vecs[5];

  logic [10:0] addrs[16];
  int n_addr, n_done, busy_low_at, done_wide_err, idle_addr_err;
  int done_cyc[8];
  logic prev_done;

  task automatic clear_mon();
    for (int i = 0; i < 16; i++) addrs[i] = '0;
    for (int i = 0; i < 8; i++) done_cyc[i] = 0;
    n_addr = 0; n_done = 0; busy_low_at = -1;
    done_wide_err = 0; idle_addr_err = 0; prev_done = 1'b0;
  endtask

  task automatic sample(input int c);
    if (rom_en) begin
      if (n_addr < 16) addrs[n_addr] = rom_addr;
      n_addr++;
    end else if (rom_addr != '0) idle_addr_err++;
    if (done) begin
      if (n_done < 8) done_cyc[n_done] = c;
      if (prev_done) done_wide_err++;
      n_done++;
    end
    prev_done = done;
    if (!busy && busy_low_at < 0) busy_low_at = c;
  endtask

  task automatic check_outputs(input string tag, input logic [4:0] t0, t1, t2, t3,
                               input logic [3:0] sol, input logic hz);
    check({tag, "_front_tile"}, 32'(front_tile), 32'(t0));
    check({tag, "_back_tile"},  32'(back_tile),  32'(t1));
    check({tag, "_up_tile"},    32'(up_tile),    32'(t2));
    check({tag, "_down_tile"},  32'(down_tile),  32'(t3));
    check({tag, "_solids"}, 32'({front_solid, back_solid, up_solid, down_solid}), 32'(sol));
    check({tag, "_hazard"}, 32'(hazard), 32'(hz));
  endtask

  initial begin
    vecs[0] = '{8'd0,   5'd3,  5'd5,  11'd49,   11'd19,   11'd33,   11'd35,
                5'd3,  5'd0,  5'd0,  5'd13, 4'b1000, 1'b1};
    vecs[1] = '{8'd0,   5'd1,  5'd1,  11'd15,   11'd2033, 11'd2047, 11'd1,
                5'd14, 5'd1,  5'd28, 5'd0,  4'b1110, 1'b1};
    vecs[2] = '{8'd2,   5'd3,  5'd5,  11'd79,   11'd49,   11'd63,   11'd65,
                5'd26, 5'd3,  5'd13, 5'd13, 4'b1100, 1'b1};
    vecs[3] = '{8'd200, 5'd10, 5'd15, 11'd1116, 11'd1086, 11'd1100, 11'd1102,
                5'd11, 5'd6,  5'd1,  5'd5,  4'b1111, 1'b1};
    vecs[4] = '{8'd1,   5'd5,  5'd3,  11'd92,   11'd62,   11'd76,   11'd78,
                5'd12, 5'd2,  5'd13, 5'd4,  4'b0000, 1'b0};

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_rom_en", 32'(rom_en), 0);
    check("rst_rom_addr", 32'(rom_addr), 0);
    check_outputs("rst", 5'd0, 5'd0, 5'd0, 5'd0, 4'b0000, 1'b0);
    @(posedge clk); #1 reset = 1'b0;

    // Reset asserted mid-probe (just after E3) aborts without a commit
    @(posedge clk); #1;
    clear_mon();
    shift_map = 8'd0; mario_x = 5'd3; mario_y = 5'd5; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 1; c <= 3; c++) begin @(posedge clk); #1; sample(c); end
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(busy), 0);
    check("abort_rom_en", 32'(rom_en), 0);
    check("abort_rom_addr", 32'(rom_addr), 0);
    check("abort_valid", 32'(valid), 0);
    check_outputs("abort", 5'd0, 5'd0, 5'd0, 5'd0, 4'b0000, 1'b0);
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;
    clear_mon();
    for (int c = 1; c <= 10; c++) begin @(posedge clk); #1; sample(c); end
    check("abort_no_done", 32'(n_done), 0);
    check("abort_valid_after", 32'(valid), 0);
    check("abort_idle_busy", 32'(busy), 0);
    check_outputs("abort_after", 5'd0, 5'd0, 5'd0, 5'd0, 4'b0000, 1'b0);

    // Table-driven single probes
    for (int i = 0; i < 5; i++) begin
      clear_mon();
      shift_map = vecs[i].s; mario_x = vecs[i].x; mario_y = vecs[i].y; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int c = 1; c <= 12 && n_done == 0; c++) begin @(posedge clk); #1; sample(c); end
      check($sformatf("v%0d_done_count", i), 32'(n_done), 1);
      check($sformatf("v%0d_done_cycle", i), 32'(done_cyc[0]), 6);
      check($sformatf("v%0d_n_addr", i), 32'(n_addr), 4);
      check($sformatf("v%0d_addr_front", i), 32'(addrs[0]), 32'(vecs[i].a0));
      check($sformatf("v%0d_addr_back", i),  32'(addrs[1]), 32'(vecs[i].a1));
      check($sformatf("v%0d_addr_up", i),    32'(addrs[2]), 32'(vecs[i].a2));
      check($sformatf("v%0d_addr_down", i),  32'(addrs[3]), 32'(vecs[i].a3));
      check($sformatf("v%0d_idle_addr", i), 32'(idle_addr_err), 0);
      check_outputs($sformatf("v%0d", i), vecs[i].t0, vecs[i].t1, vecs[i].t2,
                    vecs[i].t3, vecs[i].sol, vecs[i].hz);
      check($sformatf("v%0d_valid", i), 32'(valid), 1);
      check($sformatf("v%0d_busy_after", i), 32'(busy), 0);
      @(posedge clk); #1;
      check($sformatf("v%0d_done_width", i), 32'(done), 0);
    end

    // Inputs change mid-probe; a start during the probe yields one rerun
    clear_mon();
    shift_map = 8'd0; mario_x = 5'd3; mario_y = 5'd5; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1; sample(c);
      if (c == 2) begin mario_x = 5'd4; start = 1'b1; end
      if (c == 3) start = 1'b0;
      if (c == 6) check_outputs("rerun_first", 5'd3, 5'd0, 5'd0, 5'd13, 4'b1000, 1'b1);
    end
    check("rerun_n_addr", 32'(n_addr), 8);
    check("rerun_a0", 32'(addrs[0]), 49);
    check("rerun_a1", 32'(addrs[1]), 19);
    check("rerun_a2", 32'(addrs[2]), 33);
    check("rerun_a3", 32'(addrs[3]), 35);
    check("rerun_a4", 32'(addrs[4]), 64);
    check("rerun_a5", 32'(addrs[5]), 34);
    check("rerun_a6", 32'(addrs[6]), 48);
    check("rerun_a7", 32'(addrs[7]), 50);
    check("rerun_n_done", 32'(n_done), 2);
    check("rerun_done0", 32'(done_cyc[0]), 6);
    check("rerun_done1", 32'(done_cyc[1]), 12);
    check("rerun_busy_drop", 32'(busy_low_at), 12);
    check_outputs("rerun_second", 5'd20, 5'd2, 5'd7, 5'd12, 4'b1000, 1'b0);

    // start held high for 20 edges: back-to-back probes every 6 cycles
    clear_mon();
    shift_map = 8'd0; mario_x = 5'd3; mario_y = 5'd5; start = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1; sample(c);
      if (c == 19) start = 1'b0;
    end
    check("held_n_done", 32'(n_done), 5);
    for (int k = 0; k < 5; k++)
      check($sformatf("held_done%0d", k), 32'(done_cyc[k]), 32'(6 * (k + 1)));
    check("held_done_wide", 32'(done_wide_err), 0);
    check("held_busy_drop", 32'(busy_low_at), 30);
    check("held_idle_addr", 32'(idle_addr_err), 0);
    check("held_n_addr", 32'(n_addr), 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
